// File: rtl/jtframe_dwnld_pkg.sv
// Shared types for the ioctl-to-SDRAM download bridge: FSM states, FIFO entry
// layout and active-low byte-lane masks.
package jtframe_dwnld_pkg;

  localparam int ADDR_MAXW = 24;

  localparam logic [1:0] MASK_LO   = 2'b10;
  localparam logic [1:0] MASK_HI   = 2'b01;
  localparam logic [1:0] MASK_NONE = 2'b11;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  typedef struct packed {
    logic [ADDR_MAXW-1:0] addr;
    logic [15:0]          data;
    logic [1:0]           mask;
    logic [1:0]           ba;
  } entry_t;

endpackage

// File: rtl/jtframe_dwnld_fifo.sv
// Small synchronous FIFO; pointers carry one extra wrap bit so full and empty
// are distinguishable. A push into a full FIFO succeeds only with a pop.
module jtframe_dwnld_fifo #(
  parameter int AW = 2,
  parameter int W  = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem_q [2**AW];
  logic [AW:0]  wr_q, rd_q;
  logic         do_push, do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/jtframe_dwnld_bridge.sv
// ioctl byte stream to SDRAM programming port, buffered through a small FIFO.
// Optional running byte checksum enabled by macro JTFRAME_DWNLD_CHECKSUM_EN.
//   state   | meaning
//   S_IDLE  | no write pending; loads FIFO head onto prog_* when non-empty
//   S_WRITE | prog_we held with a stable entry until prog_rdy
module jtframe_dwnld_bridge
  import jtframe_dwnld_pkg::*;
#(
  parameter int          SDRAMW    = 23,
  parameter int          BANKS     = 4,
  parameter logic [24:0] BA1_START = 25'h100000,
  parameter logic [24:0] BA2_START = 25'h200000,
  parameter logic [24:0] BA3_START = 25'h300000,
  parameter int          HEADER    = 0,
  parameter int          FIFO_AW   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              downloading,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_data,
  input  logic              ioctl_wr,
  output logic [SDRAMW-1:0] prog_addr,
  output logic [15:0]       prog_data,
  output logic [1:0]        prog_mask,
  output logic [1:0]        prog_ba,
  output logic              prog_we,
  input  logic              prog_rdy,
  output logic              dwnld_busy,
  output logic              overflow,
  output logic [15:0]       checksum
);

  localparam logic [24:0] HDR = 25'(HEADER);
  localparam int          EW  = $bits(entry_t);

  state_t            state_q, state_d;
  entry_t            entry_in, head;
  logic [24:0]       off, base, baddr;
  logic [1:0]        bank;
  logic              hdr_ok, accept, drop, load, fifo_pop, fifo_full, fifo_empty;
  logic              dl_q, dl_rise, busy_q, ovf_q;
  logic [SDRAMW-1:0] addr_q;
  logic [15:0]       data_q;
  logic [1:0]        mask_q, ba_q;
  logic              unused_addr_hi;

  if (HEADER == 0) begin : g_nohdr
    assign hdr_ok = 1'b1;
  end else begin : g_hdr
    assign hdr_ok = (ioctl_addr >= HDR);
  end

  assign accept  = downloading && ioctl_wr && hdr_ok;
  assign drop    = accept && fifo_full && !fifo_pop;
  assign dl_rise = downloading && !dl_q;

  // Bank starts ascend, so later matches override earlier ones.
  always_comb begin
    off  = ioctl_addr - HDR;
    bank = 2'd0;
    base = '0;
    if (BANKS > 1 && off >= BA1_START) begin bank = 2'd1; base = BA1_START; end
    if (BANKS > 2 && off >= BA2_START) begin bank = 2'd2; base = BA2_START; end
    if (BANKS > 3 && off >= BA3_START) begin bank = 2'd3; base = BA3_START; end
    baddr         = off - base;
    entry_in.addr = baddr[24:1];
    entry_in.data = {ioctl_data, ioctl_data};
    entry_in.mask = baddr[0] ? MASK_HI : MASK_LO;
    entry_in.ba   = bank;
  end

  jtframe_dwnld_fifo #(.AW(FIFO_AW), .W(EW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .din   (entry_in),
    .pop   (fifo_pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!fifo_empty) state_d = S_WRITE;
      S_WRITE: if (prog_rdy)    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    load     = 1'b0;
    fifo_pop = 1'b0;
    prog_we  = 1'b0;
    case (state_q)
      S_IDLE:  load = !fifo_empty;
      S_WRITE: begin
        prog_we  = 1'b1;
        fifo_pop = prog_rdy;
      end
      default: ;
    endcase
  end

  // The head stays queued until prog_rdy, so the FIFO count includes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      data_q <= '0;
      mask_q <= MASK_NONE;
      ba_q   <= '0;
    end else if (load) begin
      addr_q <= head.addr[SDRAMW-1:0];
      data_q <= head.data;
      mask_q <= head.mask;
      ba_q   <= head.ba;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dl_q   <= 1'b0;
      busy_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      dl_q   <= downloading;
      busy_q <= downloading || !fifo_empty || (state_q != S_IDLE);
      ovf_q  <= (ovf_q && !dl_rise) || drop;
    end
  end

`ifdef JTFRAME_DWNLD_CHECKSUM_EN
  logic [15:0] csum_q;
  always_ff @(posedge clk) begin
    if (rst)                    csum_q <= '0;
    else if (accept && !drop)   csum_q <= (dl_rise ? 16'd0 : csum_q) + {8'd0, ioctl_data};
    else if (dl_rise)           csum_q <= '0;
  end
  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

  assign unused_addr_hi = ^head.addr;

  assign prog_addr  = addr_q;
  assign prog_data  = data_q;
  assign prog_mask  = mask_q;
  assign prog_ba    = ba_q;
  assign dwnld_busy = busy_q;
  assign overflow   = ovf_q;

endmodule

// File: doc/jtframe_dwnld_bridge.md
JTFRAME_DWNLD_BRIDGE -- requirements
Module: jtframe_dwnld_bridge

Interface
REQ-001 SHALL have parameter SDRAMW, default 23: SDRAM word-address width.
REQ-002 SHALL have parameter BANKS, default 4, range 1..4: number of SDRAM banks used for ROM load.
REQ-003 SHALL have parameters BA1_START, BA2_START, BA3_START, default 25'h100000, 25'h200000, 25'h300000: byte offsets where banks 1..3 begin, ascending; unused above BANKS.
REQ-004 SHALL have parameter HEADER, default 0: leading ioctl bytes discarded.
REQ-005 SHALL have parameter FIFO_AW, default 2: FIFO depth is 2**FIFO_AW entries.
REQ-006 SHALL have ports:
- clk, in, 1: single clock. Reset is synchronous and active-high.
- rst, in, 1: reset.
- downloading, in, 1: ioctl transfer active.
- ioctl_addr, in, 25: byte address.
- ioctl_data, in, 8: byte.
- ioctl_wr, in, 1: byte strobe, one cycle.
- prog_addr, out, SDRAMW: bank-relative word address.
- prog_data, out, 16: {byte,byte}.
- prog_mask, out, 2: active-low byte write mask.
- prog_ba, out, 2: bank.
- prog_we, out, 1: write request.
- prog_rdy, in, 1: one-cycle write-done pulse.
- dwnld_busy, out, 1: download or drain in progress.
- overflow, out, 1: sticky byte-drop flag.
- checksum, out, 16: running byte sum.

Function
REQ-007 SHALL ignore bytes with ioctl_addr < HEADER and all bytes while downloading=0.
REQ-008 SHALL compute off = ioctl_addr-HEADER; bank k = highest k<BANKS with off >= BAk_START (BA0_START=0); baddr = off-BAk_START.
REQ-009 SHALL form entry: prog_addr = baddr[SDRAMW:1]; prog_mask = 2'b10 if baddr[0]=0, else 2'b01; prog_data = {ioctl_data,ioctl_data}; prog_ba = k.
REQ-010 SHALL push each accepted byte into the FIFO in the same cycle as ioctl_wr.
REQ-011 SHALL drop the byte and set overflow when the FIFO is full and no pop happens that cycle; simultaneous push and pop on a full FIFO SHALL succeed.
REQ-012 SHALL run output FSM IDLE -> WRITE -> IDLE:
- IDLE with FIFO non-empty: load the head entry onto the prog_* outputs and assert prog_we next cycle.
- WRITE: hold prog_we and the entry stable until prog_rdy=1.
- On prog_rdy: pop, deassert prog_we the next cycle, return to IDLE.
REQ-013 SHALL ignore prog_rdy while in IDLE.
REQ-014 SHALL give minimum latency of 2 cycles from ioctl_wr to prog_we on an empty FIFO.
REQ-015 SHALL assert dwnld_busy = downloading | FIFO non-empty | state!=IDLE, registered; it falls no earlier than the cycle after the last prog_rdy.
REQ-016 SHALL wrap FIFO pointers modulo 2**FIFO_AW, with full/empty distinguished by an extra pointer bit.
REQ-017 SHALL clear overflow and checksum on the rising edge of downloading.

Reset
REQ-018 SHALL, on rst=1, regardless of the ongoing transfer:
- empty the FIFO and force state IDLE;
- drive prog_we=0, prog_addr=0, prog_data=0, prog_mask=2'b11, prog_ba=0;
- drive dwnld_busy=0, overflow=0, checksum=0.
REQ-019 SHALL discard a write that is in flight when reset asserts; no prog_we SHALL be issued in the cycle after rst falls.

Configuration
REQ-020 SHALL, when macro JTFRAME_DWNLD_CHECKSUM_EN is defined, add each accepted (post-header) byte to checksum modulo 2**16; dropped bytes are not counted.
REQ-021 SHALL, without JTFRAME_DWNLD_CHECKSUM_EN, tie checksum to 0 and synthesise no adder logic.

Structure
REQ-022 SHALL place the FSM state enum, the FIFO entry struct {addr,data,mask,ba} and the byte-lane mask constants in package jtframe_dwnld_pkg.
REQ-023 SHALL implement the FIFO as sub-module jtframe_dwnld_fifo, parametrised by FIFO_AW and entry width.

Verification
REQ-024 SHALL cover: HEADER=0, bytes 0x12@0, 0x34@1, prog_rdy 3 cycles after each prog_we -> two writes at prog_addr 0, masks 2'b10 then 2'b01, data 16'h1212 then 16'h3434, ba 0.
REQ-025 SHALL cover: BANKS=4, byte at 25'h200005 -> prog_ba=2, prog_addr=2, prog_mask=2'b01.
REQ-026 SHALL cover: HEADER=16, bytes at addresses 0..15 -> no prog_we; byte at 16 -> prog_addr 0, prog_mask 2'b10.
REQ-027 SHALL cover: FIFO_AW=2, prog_rdy held low, 6 bytes -> 4 queued, overflow=1, 4 writes after prog_rdy resumes.
REQ-028 SHALL cover: rst pulsed while prog_we=1 with 3 entries queued -> next cycle prog_we=0, dwnld_busy=0, later prog_rdy ignored.
REQ-029 SHALL cover: JTFRAME_DWNLD_CHECKSUM_EN defined, bytes 0xFF,0xFF,0x02 -> checksum=16'h0200; macro undefined -> checksum=0.
